sine_meas: RTL and testbench

SINE_MEAS -- requirements
Module: sine_meas

---
 rtl/sine_pkg.sv | 16 +
 rtl/sine_xdet.sv | 41 ++++
 rtl/sine_meas.sv | 132 +++++++++++++
 tb/tb_sine_meas.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sine_pkg.sv
// Shared definitions for the sine oscillator blocks (sine_gen, sine_meas).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sine_pkg;

    // Default widths shared with sine_gen users.
    localparam int SW_DEF = 20;   // sample width, two's complement
    localparam int CW_DEF = 16;   // period counter width

    // Measurement FSM encoding.
    typedef enum logic {
        SEEK    = 1'b0,
        MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/sine_xdet.sv
// Positive-going zero-crossing detector with hysteresis arming.
// Latency: crossing is combinational on the en cycle; armed updates on the next edge.
// Backpressure: none; evaluates every en=1 sample.
// Ports: clk/reset, en + sample (input strobe and value), disarm (forces armed low),
//        crossing (armed and sample >= 0 on an en cycle).
module sine_xdet
    import sine_pkg::*;
#(
    parameter int SW   = SW_DEF,
    parameter int HYST = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic signed [SW-1:0] sample,
    input  logic                 disarm,
    output logic                 crossing
);

    localparam logic signed [SW-1:0] NEG_HYST = SW'(-HYST);

    logic armed;

    // Non-negative test is the sign bit alone.
    assign crossing = en && armed && !sample[SW-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed <= 1'b0;
        end else if (en) begin
            // Disarm (timeout abort) wins over re-arming on the same sample.
            if (disarm)
                armed <= 1'b0;
            else if (sample <= NEG_HYST)
                armed <= 1'b1;
            else if (crossing)
                armed <= 1'b0;
        end
    end

endmodule

// File: rtl/sine_meas.sv
// Measures period (samples/cycle), peak, trough and peak-to-peak of an oscillator stream.
// Latency: meas_valid rises one clk after the en cycle of the closing crossing.
// Backpressure: valid/ready output; an unread result is overwritten and flags sticky overrun.
// Ports: clk/reset, en + sample in; meas_valid/meas_ready with period, peak, trough,
//        amp_pp out; timeout/reject single-cycle pulses; overrun sticky until reset.
module sine_meas
    import sine_pkg::*;
#(
    parameter int SW         = SW_DEF,
    parameter int CW         = CW_DEF,
    parameter int HYST       = 64,
    parameter int MIN_PERIOD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic signed [SW-1:0] sample,
    output logic                 meas_valid,
    input  logic                 meas_ready,
    output logic [CW-1:0]        period,
    output logic signed [SW-1:0] peak,
    output logic signed [SW-1:0] trough,
    output logic signed [SW:0]   amp_pp,
    output logic                 timeout,
    output logic                 reject,
    output logic                 overrun
);

    state_t                state;
    logic [CW-1:0]         count;
    logic signed [SW-1:0]  peak_acc;
    logic signed [SW-1:0]  trough_acc;

    logic                  crossing;
    logic                  timeout_hit;
    logic signed [SW-1:0]  pk_next;
    logic signed [SW-1:0]  tr_next;
    logic signed [SW:0]    amp_next;
    logic [CW:0]           p_next;
    logic                  p_ok;
    logic [CW-1:0]         p_sat;

    sine_xdet #(
        .SW   (SW),
        .HYST (HYST)
    ) u_xdet (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .sample   (sample),
        .disarm   (timeout_hit),
        .crossing (crossing)
    );

    // Window would exceed 2^CW-1 samples on this en cycle.
    assign timeout_hit = en && (state == MEASURE) && !crossing && (&count);

    assign pk_next  = (sample > peak_acc)   ? sample : peak_acc;
    assign tr_next  = (sample < trough_acc) ? sample : trough_acc;
    // One extra bit of headroom makes the difference exact.
    assign amp_next = {pk_next[SW-1], pk_next} - {tr_next[SW-1], tr_next};

    assign p_next = {1'b0, count} + (CW+1)'(1);
    assign p_ok   = (p_next >= (CW+1)'(MIN_PERIOD));
    // A crossing landing exactly on a full counter gives 2^CW, which does not fit; clamp.
    assign p_sat  = p_next[CW] ? {CW{1'b1}} : p_next[CW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= SEEK;
            count      <= '0;
            peak_acc   <= '0;
            trough_acc <= '0;
            period     <= '0;
            peak       <= '0;
            trough     <= '0;
            amp_pp     <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            reject     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            timeout <= 1'b0;
            reject  <= 1'b0;

            // Consumer handshake; a load below in the same cycle overrides this.
            if (meas_valid && meas_ready)
                meas_valid <= 1'b0;

            if (en) begin
                case (state)
                    SEEK: begin
                        if (crossing) begin
                            state      <= MEASURE;
                            count      <= '0;
                            peak_acc   <= sample;
                            trough_acc <= sample;
                        end
                    end
                    MEASURE: begin
                        if (crossing) begin
                            // Close the window and immediately open the next one.
                            count      <= '0;
                            peak_acc   <= sample;
                            trough_acc <= sample;
                            if (p_ok) begin
                                period     <= p_sat;
                                peak       <= pk_next;
                                trough     <= tr_next;
                                amp_pp     <= amp_next;
                                meas_valid <= 1'b1;
                                if (meas_valid && !meas_ready)
                                    overrun <= 1'b1;
                            end else begin
                                reject <= 1'b1;
                            end
                        end else if (timeout_hit) begin
                            timeout <= 1'b1;
                            state   <= SEEK;
                            count   <= '0;
                        end else begin
                            count      <= count + 1'b1;
                            peak_acc   <= pk_next;
                            trough_acc <= tr_next;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sine_meas.sv
// Directed self-checking bench for sine_meas (default parameters).
// Latency: n/a.
// Backpressure: n/a.
module tb_sine_meas;
    import sine_pkg::*;

    logic               clk;
    logic               reset;
    logic               en;
    logic signed [19:0] sample;
    logic               meas_valid;
    logic               meas_ready;
    logic [15:0]        period;
    logic signed [19:0] peak;
    logic signed [19:0] trough;
    logic signed [20:0] amp_pp;
    logic               timeout;
    logic               reject;
    logic               overrun;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic signed [19:0] P10  = 20'sd10;
    localparam logic signed [19:0] N10  = -20'sd10;
    localparam logic signed [19:0] P100 = 20'sd100;
    localparam logic signed [19:0] N100 = -20'sd100;
    localparam logic signed [19:0] P150 = 20'sd150;
    localparam logic signed [19:0] N200 = -20'sd200;

    sine_meas dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .sample     (sample),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .period     (period),
        .peak       (peak),
        .trough     (trough),
        .amp_pp     (amp_pp),
        .timeout    (timeout),
        .reject     (reject),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one input vector, let one rising edge consume it, settle 1 time unit.
    task automatic step(input logic e, input logic signed [19:0] s);
        en     = e;
        sample = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic seen;

        reset      = 1'b0;
        en         = 1'b0;
        sample     = '0;
        meas_ready = 1'b0;
        #12;

        // Reset state
        chk("rst_valid",   meas_valid, 0);
        chk("rst_period",  period, 0);
        chk("rst_peak",    peak, 0);
        chk("rst_trough",  trough, 0);
        chk("rst_amp",     amp_pp, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_reject",  reject, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_state",   int'(dut.state), int'(SEEK));
        reset = 1'b1;

        // Small noise never arms: no activity at all
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, (i % 2 == 0) ? N10 : P10);
            if (meas_valid || reject || timeout) seen = 1'b1;
        end
        chk("noise_activity", seen, 0);
        chk("noise_state", int'(dut.state), int'(SEEK));

        // Square wave, period 8, consumer always ready
        meas_ready = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, N100);
        for (int i = 0; i < 4; i++) step(1'b1, P100);   // first crossing opens window
        for (int i = 0; i < 4; i++) step(1'b1, N100);
        chk("sq_no_early_valid", meas_valid, 0);
        chk("sq_state", int'(dut.state), int'(MEASURE));
        step(1'b1, P100);                                // closing crossing
        chk("sq_valid",   meas_valid, 1);
        chk("sq_period",  period, 8);
        chk("sq_peak",    peak, 100);
        chk("sq_trough",  trough, -100);
        chk("sq_amp",     amp_pp, 200);
        chk("sq_overrun", overrun, 0);
        step(1'b1, P100);
        chk("sq_valid_drop", meas_valid, 0);
        chk("sq_peak_hold",  peak, 100);
        step(1'b1, P100);
        step(1'b1, P100);

        // Two measurements with consumer stalled -> overrun
        meas_ready = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, N100);
        step(1'b1, P100);
        chk("ov_first_valid",   meas_valid, 1);
        chk("ov_first_overrun", overrun, 0);
        for (int i = 0; i < 3; i++) step(1'b1, P100);
        for (int i = 0; i < 4; i++) step(1'b1, N200);
        step(1'b1, P150);
        chk("ov_valid",   meas_valid, 1);
        chk("ov_period",  period, 8);
        chk("ov_peak",    peak, 150);
        chk("ov_trough",  trough, -200);
        chk("ov_amp",     amp_pp, 350);
        chk("ov_overrun", overrun, 1);
        meas_ready = 1'b1;
        step(1'b0, P100);                                // en=0: only the handshake moves
        chk("ov_valid_drop",  meas_valid, 0);
        chk("ov_sticky",      overrun, 1);
        chk("ov_state_hold",  int'(dut.state), int'(MEASURE));

        // Period-2 alternation is rejected
        step(1'b1, N100);
        chk("rej_idle", reject, 0);
        step(1'b1, P100);
        chk("rej_pulse1", reject, 1);
        step(1'b1, N100);
        chk("rej_single_cycle", reject, 0);
        step(1'b1, P100);
        chk("rej_pulse2", reject, 1);
        chk("rej_no_valid", meas_valid, 0);
        for (int i = 0; i < 3; i++) step(1'b1, P100);
        for (int i = 0; i < 4; i++) step(1'b1, N100);
        step(1'b1, P100);
        chk("rej_then_valid",  meas_valid, 1);
        chk("rej_then_period", period, 8);
        chk("rej_then_amp",    amp_pp, 200);

        // Window never closes -> timeout after 2^16-1 counted samples
        seen = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            step(1'b1, N100);
            if (timeout) seen = 1'b1;
        end
        chk("tmo_early", seen, 0);
        step(1'b1, N100);
        chk("tmo_pulse", timeout, 1);
        chk("tmo_state", int'(dut.state), int'(SEEK));
        step(1'b1, N100);
        chk("tmo_single_cycle", timeout, 0);
        chk("tmo_no_valid", meas_valid, 0);

        // Build a report, then reset asynchronously mid-window
        meas_ready = 1'b0;
        step(1'b1, P100);
        for (int i = 0; i < 3; i++) step(1'b1, P100);
        for (int i = 0; i < 4; i++) step(1'b1, N100);
        step(1'b1, P100);
        chk("pre_rst_valid", meas_valid, 1);
        for (int i = 0; i < 3; i++) step(1'b1, P100);
        for (int i = 0; i < 2; i++) step(1'b1, N100);
        #1 reset = 1'b0;
        #1;
        chk("arst_valid",   meas_valid, 0);
        chk("arst_period",  period, 0);
        chk("arst_peak",    peak, 0);
        chk("arst_trough",  trough, 0);
        chk("arst_amp",     amp_pp, 0);
        chk("arst_overrun", overrun, 0);
        chk("arst_state",   int'(dut.state), int'(SEEK));
        #1 reset = 1'b1;

        // First crossing after reset only opens a window
        meas_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin step(1'b1, N100); if (meas_valid) seen = 1'b1; end
        for (int i = 0; i < 4; i++) begin step(1'b1, P100); if (meas_valid) seen = 1'b1; end
        for (int i = 0; i < 4; i++) begin step(1'b1, N100); if (meas_valid) seen = 1'b1; end
        chk("post_rst_no_report", seen, 0);
        step(1'b1, P100);
        chk("post_rst_valid",  meas_valid, 1);
        chk("post_rst_period", period, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
